// File: rtl/folded_neuron_layer.sv
// Fully-connected neuron layer folded onto NUM_MACS shared fixed-point MAC lanes,
// with runtime-writable weights/biases and an optional saturate + ReLU output stage.
module folded_neuron_layer #(
  parameter int DATA_WIDTH    = 32,
  parameter int FRACTION      = 24,
  parameter int NUM_NEURONS   = 32,
  parameter int NEURON_INPUTS = 5,
  parameter int NUM_MACS      = 4,
  parameter int ACTIVATION    = 0,
  parameter int SATURATE      = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  output logic                                       wr_ready,
  input  logic                                       wr_en,
  input  logic [$clog2(NUM_NEURONS)-1:0]             wr_neuron,
  input  logic [$clog2(NEURON_INPUTS+1)-1:0]         wr_index,
  input  logic [DATA_WIDTH-1:0]                      wr_data,
  output logic                                       ready_in,
  input  logic                                       valid_in,
  input  logic [NEURON_INPUTS-1:0][DATA_WIDTH-1:0]   data_in,
  input  logic                                       ready_out,
  output logic                                       valid_out,
  output logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]     data_out,
  output logic [1:0]                                 o_dbg_state
);
  localparam int NUM_GROUPS = NUM_NEURONS / NUM_MACS;
  localparam int NW = $clog2(NUM_NEURONS);
  localparam int XW = $clog2(NEURON_INPUTS + 1);
  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int IW = (NEURON_INPUTS > 1) ? $clog2(NEURON_INPUTS) : 1;
  // Wide enough for a full shifted product plus every term of the dot product,
  // so the saturation decision always sees the exact sum.
  localparam int ACC_W = 2*DATA_WIDTH - FRACTION + XW + 1;

  localparam logic [GW-1:0] LAST_G   = GW'(NUM_GROUPS - 1);
  localparam logic [IW-1:0] LAST_I   = IW'(NEURON_INPUTS - 1);
  localparam logic [XW-1:0] BIAS_IDX = XW'(NEURON_INPUTS);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
  // ready_in/wr_ready/valid_out decode only the registered state.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COMPUTE = 2'd1, S_OUTPUT = 2'd2} state_t;

  logic [DATA_WIDTH-1:0]                     r_coef [NUM_NEURONS][NEURON_INPUTS+1];
  state_t                                    r_state, w_next;
  logic [GW-1:0]                             r_g, w_g_next, w_bias_grp;
  logic [IW-1:0]                             r_i;
  logic [NEURON_INPUTS-1:0][DATA_WIDTH-1:0]  r_x;
  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]    r_result;
  logic signed [ACC_W-1:0]                   r_acc [NUM_MACS];

  logic                           w_idle, w_accept, w_wr, w_last_i;
  logic [DATA_WIDTH-1:0]          w_x;
  logic [NW-1:0]                  w_n_cur  [NUM_MACS];
  logic [NW-1:0]                  w_n_bias [NUM_MACS];
  logic [DATA_WIDTH-1:0]          w_wt     [NUM_MACS];
  logic [DATA_WIDTH-1:0]          w_bias   [NUM_MACS];
  logic signed [ACC_W-1:0]        w_bias_ext [NUM_MACS];
  logic signed [2*DATA_WIDTH-1:0] w_full   [NUM_MACS];
  logic signed [ACC_W-1:0]        w_prod   [NUM_MACS];
  logic signed [ACC_W-1:0]        w_sum    [NUM_MACS];
  logic [DATA_WIDTH-1:0]          w_sat    [NUM_MACS];
  logic [DATA_WIDTH-1:0]          w_res    [NUM_MACS];

  assign w_idle      = (r_state == S_IDLE);
  assign ready_in    = w_idle;
  assign wr_ready    = w_idle;
  assign valid_out   = (r_state == S_OUTPUT);
  assign data_out    = r_result;
  assign o_dbg_state = r_state;
  assign w_accept    = w_idle & valid_in;
  assign w_wr        = wr_en & wr_ready & (int'(wr_neuron) < NUM_NEURONS) & (int'(wr_index) <= NEURON_INPUTS);
  assign w_last_i    = (r_i == LAST_I);
  assign w_x         = r_x[r_i];
  assign w_g_next    = (r_g == LAST_G) ? '0 : r_g + GW'(1);
  assign w_bias_grp  = w_idle ? '0 : w_g_next;

  always_comb begin
    for (int l = 0; l < NUM_MACS; l++) begin
      w_n_cur[l]  = NW'(int'(r_g) * NUM_MACS + l);
      w_n_bias[l] = NW'(int'(w_bias_grp) * NUM_MACS + l);
      w_wt[l]     = r_coef[w_n_cur[l]][r_i];
      // A bias written on the accept edge must already feed the accumulator load.
      w_bias[l]   = (w_wr && wr_index == BIAS_IDX && wr_neuron == w_n_bias[l]) ?
                    wr_data : r_coef[w_n_bias[l]][NEURON_INPUTS];
      w_bias_ext[l] = {{(ACC_W-DATA_WIDTH){w_bias[l][DATA_WIDTH-1]}}, w_bias[l]};
      w_full[l] = $signed({{DATA_WIDTH{w_x[DATA_WIDTH-1]}}, w_x}) *
                  $signed({{DATA_WIDTH{w_wt[l][DATA_WIDTH-1]}}, w_wt[l]});
      w_prod[l] = ACC_W'(w_full[l] >>> FRACTION);
      w_sum[l]  = r_acc[l] + w_prod[l];
      w_sat[l]  = w_sum[l][DATA_WIDTH-1:0];
      if (SATURATE != 0 && w_sum[l] > SAT_MAX)      w_sat[l] = SAT_MAX[DATA_WIDTH-1:0];
      else if (SATURATE != 0 && w_sum[l] < SAT_MIN) w_sat[l] = SAT_MIN[DATA_WIDTH-1:0];
      w_res[l] = (ACTIVATION != 0 && w_sat[l][DATA_WIDTH-1]) ? '0 : w_sat[l];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (valid_in) w_next = S_COMPUTE;
      S_COMPUTE: if (r_g == LAST_G && w_last_i) w_next = S_OUTPUT;
      S_OUTPUT:  if (ready_out) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Coefficients deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_coef[wr_neuron][wr_index] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_g      <= '0;
      r_i      <= '0;
      r_x      <= '0;
      r_result <= '0;
      for (int l = 0; l < NUM_MACS; l++) r_acc[l] <= '0;
    end else if (w_accept) begin
      r_x <= data_in;
      r_g <= '0;
      r_i <= '0;
      for (int l = 0; l < NUM_MACS; l++) r_acc[l] <= w_bias_ext[l];
    end else if (r_state == S_COMPUTE) begin
      if (w_last_i) begin
        for (int l = 0; l < NUM_MACS; l++) begin
          r_result[w_n_cur[l]] <= w_res[l];
          r_acc[l]             <= w_bias_ext[l];
        end
        r_i <= '0;
        r_g <= w_g_next;
      end else begin
        for (int l = 0; l < NUM_MACS; l++) r_acc[l] <= w_sum[l];
        r_i <= r_i + IW'(1);
      end
    end
  end
endmodule
